// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, taken-branch
// and data-memory wait events into one set of pipeline-register controls.
module pipeline_stall_ctrl #(
  parameter int LU_STALL = 1,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_hold_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0]  LU_INIT = 4'(LU_STALL - 1);
  localparam logic [15:0] TO_VAL  = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [3:0]        lu_cnt_q, lu_cnt_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]       wait_inc;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic mem_stall;
  logic do_freeze;
  logic do_branch;
  logic do_lu;

  assign mem_stall = dmem_req_i & ~dmem_ack_i;
  assign wait_inc  = wait_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    do_freeze  = 1'b0;
    do_branch  = 1'b0;
    do_lu      = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        // Frozen pipeline: branch and load-use are re-presented after release.
        do_freeze = 1'b1;
        if (dmem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_inc == TO_VAL) begin
          err_d      = 1'b1;
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      LD_STALL: begin
        if (mem_stall) begin
          do_freeze  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd1;
          lu_cnt_d   = 4'd0;
        end else if (branch_taken_i) begin
          do_branch = 1'b1;
          state_d   = RUN;
          lu_cnt_d  = 4'd0;
        end else begin
          do_lu    = 1'b1;
          lu_cnt_d = lu_cnt_q - 4'd1;
          if (lu_cnt_q <= 4'd1) begin
            state_d  = RUN;
            lu_cnt_d = 4'd0;
          end
        end
      end

      // RUN, and any unknown encoding, behaves as RUN.
      default: begin
        state_d = RUN;
        if (mem_stall) begin
          do_freeze  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd1;
        end else if (branch_taken_i) begin
          do_branch = 1'b1;
        end else if (load_use_i) begin
          do_lu = 1'b1;
          if (LU_STALL > 1) begin
            state_d  = LD_STALL;
            lu_cnt_d = LU_INIT;
          end
        end
      end
    endcase
  end

  assign pc_write_o     = ~(do_freeze | do_lu);
  assign ifid_write_o   = ~(do_freeze | do_lu);
  assign ifid_flush_o   = do_branch;
  assign idex_flush_o   = do_branch | do_lu;
  assign exmem_hold_o   = do_freeze;
  assign memwb_bubble_o = do_freeze;
  assign err_o          = err_q;
  assign stall_cnt_o    = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      lu_cnt_q    <= 4'd0;
      wait_cnt_q  <= 16'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline CPU.
- Merges three event sources into one consistent set of pipeline-register write/flush controls:
  - load-use hazard indication from the ID-stage hazard detector;
  - taken-branch redirect from EX;
  - variable-latency data-memory handshake from MEM.
- Sits between those sources and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Adds multi-cycle load-use stalls, memory-wait freezing with timeout, and a stall-cycle performance counter.

Parameters:
- LU_STALL, 1, load-use stall length in cycles (1..15); 2 for builds without forwarding.
- TIMEOUT, 64, maximum MEM_WAIT cycles before forced release (2..65535).
- CNT_W, 16, stall counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- load_use_i  input  1  load-use hazard detected in ID (from hazard detector).
- branch_taken_i  input  1  branch/jump resolved taken in EX.
- dmem_req_i  input  1  MEM stage instruction accesses data memory this cycle.
- dmem_ack_i  input  1  data memory completes the access this cycle.
- pc_write_o  output  1  PC register write enable.
- ifid_write_o  output  1  IF/ID write enable.
- ifid_flush_o  output  1  IF/ID clear to NOP.
- idex_flush_o  output  1  ID/EX control fields zeroed (bubble).
- exmem_hold_o  output  1  EX/MEM and ID/EX hold (no write).
- memwb_bubble_o  output  1  MEM/WB receives bubble.
- err_o  output  1  sticky memory timeout flag.
- stall_cnt_o  output  CNT_W  cycles with pc_write_o=0, saturating.

Behaviour:
- Outputs are Mealy: decoded combinationally from state and inputs, so a stall takes effect in the cycle the event is presented.
- States:
  - RUN (reset);
  - LD_STALL;
  - MEM_WAIT.
- Internal counters:
  - lu_cnt (4 bits);
  - wait_cnt (16 bits).
- Default (RUN, no event): pc_write=1, ifid_write=1, all flush/hold/bubble outputs 0.
- RUN, priority high to low:
  - dmem_req_i & !dmem_ack_i -> freeze: pc_write=0, ifid_write=0, exmem_hold=1, memwb_bubble=1. Next state MEM_WAIT, wait_cnt<=1.
  - branch_taken_i -> pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. Stay RUN.
  - load_use_i -> pc_write=0, ifid_write=0, idex_flush=1. If LU_STALL>1, go to LD_STALL with lu_cnt<=LU_STALL-1; else stay RUN.
  - dmem_req_i & dmem_ack_i (single-cycle access) is treated as no event.
- LD_STALL:
  - Outputs pc_write=0, ifid_write=0, idex_flush=1; lu_cnt decrements.
  - On lu_cnt==1, return to RUN.
  - Memory-wait condition preempts: freeze outputs, go to MEM_WAIT; the remaining load stall is dropped because the load-use detector re-asserts after release if still needed.
  - branch_taken_i preempts: branch outputs, go to RUN (flush kills the dependent instruction).
- MEM_WAIT:
  - Freeze outputs every cycle, including the ack cycle.
  - dmem_ack_i -> RUN next cycle.
  - Otherwise wait_cnt increments. When wait_cnt==TIMEOUT, set err_o=1 and go to RUN.
  - branch_taken_i and load_use_i are ignored here; the pipeline is frozen, so they are re-presented after release.
- err_o: sticky until reset.
- stall_cnt_o: increments on every clock edge where pc_write_o==0; saturates at all-ones.
- Reset asserted at any time, including mid-MEM_WAIT or mid-LD_STALL:
  - state=RUN, lu_cnt=0, wait_cnt=0, err_o=0, stall_cnt_o=0;
  - with inputs low, outputs are pc_write=1, ifid_write=1, others 0.
- No X-propagation: an unknown state decodes as RUN.

Test Plan:
- Reset low then high, all inputs 0 -> pc_write_o=1, ifid_write_o=1, flush/hold/bubble=0, stall_cnt_o=0, err_o=0.
- LU_STALL=2, load_use_i=1 for one cycle -> exactly 2 cycles of pc_write_o=0 with idex_flush_o=1, then RUN; stall_cnt_o=2.
- dmem_req_i=1, dmem_ack_i after 3 cycles -> 4 frozen cycles (exmem_hold_o=1, memwb_bubble_o=1) including the ack cycle, RUN on the 5th; stall_cnt_o=4.
- load_use_i, branch_taken_i and dmem_req_i (no ack) asserted together -> memory freeze wins and MEM_WAIT is entered. After ack, branch_taken_i held high -> one cycle with ifid_flush_o=1 and idex_flush_o=1.
- TIMEOUT=4, dmem_req_i=1, never ack -> err_o=1 after 4 frozen cycles, return to RUN, err_o stays 1 until reset.
- Reset pulsed during MEM_WAIT cycle 2 -> immediate RUN outputs, counters 0; with CNT_W=2, 5 stall cycles -> stall_cnt_o saturates at 3.
